fetch_queue: RTL and testbench

- Next-generation 6502 instruction fetcher, parametrised in address width, data width and prefetch depth.
- Decouples memory fetch from execute. Sequential bytes are prefetched into a FIFO, then whole instructions (opcode plus 0–2 operand bytes) are assembled and handed to the executer over a valid/ready handshake.
- Adds redirect/flush for branches, jumps, JSR, RTS, RTI and interrupts. Sits between the memory arbiter and the execute unit.

---
 rtl/fetch_queue.sv | 161 ++++++++++++++++
 tb/tb_fetch_queue.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - 6502 instruction prefetch FIFO with whole-instruction assembly and redirect flush
module fetch_queue #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int QDEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = 16'h8000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  output logic                    mem_req,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_ack,
  input  logic                    redirect,
  input  logic [ADDR_WIDTH-1:0]   redirect_pc,
  output logic                    instr_valid,
  input  logic                    instr_ready,
  output logic [DATA_WIDTH-1:0]   instr_opcode,
  output logic [2*DATA_WIDTH-1:0] instr_operand,
  output logic [1:0]              instr_len,
  output logic [ADDR_WIDTH-1:0]   instr_pc,
  output logic [$clog2(QDEPTH):0] q_count
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(QDEPTH);
  localparam logic [DATA_WIDTH-1:0] ZERO_BYTE = '0;

  typedef enum logic {IDLE, WAIT} fetch_state_t;

  fetch_state_t state, state_next;
  logic [ADDR_WIDTH-1:0] fetch_pc, fetch_pc_next, mem_addr_next;
  logic discard, discard_next;

  logic [DATA_WIDTH-1:0] q_data [QDEPTH];
  logic [ADDR_WIDTH-1:0] q_addr [QDEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, rd_ptr1, rd_ptr2;
  logic [DATA_WIDTH-1:0] head, byte1, byte2;
  logic [1:0] head_len;
  logic push, pop;
  logic [CW-1:0] count_next;

  function automatic logic [1:0] decode_len(input logic [DATA_WIDTH-1:0] o);
    logic [1:0] cc;
    logic [2:0] bbb;
    logic [1:0] len;
    cc = o[1:0];
    bbb = o[4:2];
    len = 2'd2;
    if (cc == 2'b11) begin
      len = 2'd1;
    end else if (cc == 2'b01) begin
      if (bbb == 3'b011 || bbb == 3'b110 || bbb == 3'b111) len = 2'd3;
    end else begin
      case (bbb)
        // BRK/RTI/RTS are single byte, JSR carries an absolute address
        3'b000: begin
          if (o == DATA_WIDTH'(8'h20)) len = 2'd3;
          else if (o == DATA_WIDTH'(8'h00) || o == DATA_WIDTH'(8'h40) || o == DATA_WIDTH'(8'h60)) len = 2'd1;
        end
        3'b011, 3'b111: len = 2'd3;
        3'b010, 3'b110: len = 2'd1;
        3'b100: if (cc == 2'b10) len = 2'd1;
        default: len = 2'd2;
      endcase
    end
    return len;
  endfunction

  assign rd_ptr1  = rd_ptr + PW'(1);
  assign rd_ptr2  = rd_ptr + PW'(2);
  assign head     = q_data[rd_ptr];
  assign byte1    = q_data[rd_ptr1];
  assign byte2    = q_data[rd_ptr2];
  assign head_len = decode_len(head);

  assign mem_req    = (state == WAIT);
  assign pop        = !redirect && (!instr_valid || instr_ready) && (q_count >= CW'(head_len));
  assign push       = (state == WAIT) && mem_ack && !discard && !redirect;
  assign count_next = redirect ? '0 : q_count + CW'(push) - (pop ? CW'(head_len) : '0);

  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    mem_addr_next = mem_addr;
    discard_next  = discard;
    case (state)
      IDLE: begin
        if (redirect) fetch_pc_next = redirect_pc;
        if (redirect || q_count < FULL) begin
          state_next    = WAIT;
          mem_addr_next = fetch_pc_next;
        end
      end
      WAIT: begin
        if (mem_ack) begin
          discard_next = 1'b0;
          if (redirect) fetch_pc_next = redirect_pc;
          else if (!discard) fetch_pc_next = fetch_pc + ADDR_WIDTH'(1);
          if (count_next < FULL) mem_addr_next = fetch_pc_next;
          else state_next = IDLE;
        end else if (redirect) begin
          // request already on the bus: keep it stable and throw its data away
          discard_next  = 1'b1;
          fetch_pc_next = redirect_pc;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      fetch_pc      <= RESET_PC;
      mem_addr      <= RESET_PC;
      discard       <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      q_count       <= '0;
      instr_valid   <= 1'b0;
      instr_opcode  <= '0;
      instr_operand <= '0;
      instr_len     <= '0;
      instr_pc      <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        q_data[i] <= '0;
        q_addr[i] <= '0;
      end
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      mem_addr <= mem_addr_next;
      discard  <= discard_next;
      q_count  <= count_next;
      if (redirect) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) begin
          q_data[wr_ptr] <= mem_rdata;
          q_addr[wr_ptr] <= mem_addr;
          wr_ptr         <= wr_ptr + PW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(head_len);
      end
      if (redirect) begin
        instr_valid <= 1'b0;
      end else if (pop) begin
        instr_valid   <= 1'b1;
        instr_opcode  <= head;
        instr_operand <= {(head_len == 2'd3) ? byte2 : ZERO_BYTE,
                          (head_len != 2'd1) ? byte1 : ZERO_BYTE};
        instr_len     <= head_len;
        instr_pc      <= q_addr[rd_ptr];
      end else if (instr_ready) begin
        instr_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - self-checking bench for fetch_queue: directed scenarios plus random traffic vs a memory-image model
module tb_fetch_queue;
  localparam logic [15:0] RESET_PC = 16'h8000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata = 8'h00;
  logic        mem_ack = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [7:0]  instr_opcode;
  logic [15:0] instr_operand;
  logic [1:0]  instr_len;
  logic [15:0] instr_pc;
  logic [2:0]  q_count;

  fetch_queue #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .QDEPTH(4), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset_n(reset_n),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_opcode(instr_opcode),
    .instr_operand(instr_operand), .instr_len(instr_len), .instr_pc(instr_pc), .q_count(q_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  int n_accepted = 0;
  logic [7:0] mem [0:65535];

  int fixed_lat = 0;
  int lat = 0;
  int wait_cnt = 0;
  bit late_ack_arm = 0;
  logic prev_req = 1'b0;
  logic prev_ack = 1'b0;
  logic [15:0] prev_addr = 16'h0;

  logic [15:0] exp_pc = RESET_PC;
  logic sv_valid = 1'b0;
  logic [7:0] sv_op;
  logic [15:0] sv_operand, sv_pc;
  logic [1:0] sv_len;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int ref_len(input logic [7:0] o);
    int cc, bbb;
    cc = int'(o) % 4;
    bbb = (int'(o) / 4) % 8;
    if (cc == 3) return 1;
    if (cc == 1) return (bbb == 3 || bbb == 6 || bbb == 7) ? 3 : 2;
    if (o == 8'h20) return 3;
    if (o == 8'h00 || o == 8'h40 || o == 8'h60) return 1;
    if (bbb == 0 || bbb == 1 || bbb == 5) return 2;
    if (bbb == 3 || bbb == 7) return 3;
    if (bbb == 2 || bbb == 6) return 1;
    return (cc == 0) ? 2 : 1;
  endfunction

  function automatic logic [15:0] ref_operand(input logic [15:0] pc);
    int n;
    logic [15:0] a1, a2;
    logic [7:0] lo, hi;
    n = ref_len(mem[pc]);
    a1 = pc + 16'd1;
    a2 = pc + 16'd2;
    lo = (n >= 2) ? mem[a1] : 8'h00;
    hi = (n == 3) ? mem[a2] : 8'h00;
    return {hi, lo};
  endfunction

  // Expected instruction stream: walk the memory image from the current pc
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_pc = RESET_PC;
    end else begin
      if (sv_valid && !redirect) begin
        if (instr_ready) begin
          check("sb_pc", sv_pc, exp_pc);
          check("sb_opcode", sv_op, mem[exp_pc]);
          check("sb_len", sv_len, ref_len(mem[exp_pc]));
          check("sb_operand", sv_operand, ref_operand(exp_pc));
          exp_pc = exp_pc + 16'(ref_len(mem[exp_pc]));
          n_accepted++;
        end else begin
          check("hold", {instr_valid, instr_opcode, instr_operand, instr_len, instr_pc},
                {1'b1, sv_op, sv_operand, sv_len, sv_pc});
        end
      end
      if (redirect) exp_pc = redirect_pc;
    end
    sv_valid = instr_valid;
    sv_op = instr_opcode;
    sv_operand = instr_operand;
    sv_len = instr_len;
    sv_pc = instr_pc;
  end

  always @(negedge clk) begin
    if (reset_n && prev_req && !prev_ack)
      check("mem_hold", {mem_req, mem_addr}, {1'b1, prev_addr});
    if (late_ack_arm) begin
      late_ack_arm = 0;
      mem_ack = 1'b1;
      mem_rdata = 8'($urandom);
    end else begin
      if (mem_ack) begin
        wait_cnt = 0;
        lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
      end
      if (mem_req === 1'b1 && wait_cnt >= lat) begin
        mem_ack = 1'b1;
        mem_rdata = mem[mem_addr];
      end else begin
        mem_ack = 1'b0;
        mem_rdata = 8'($urandom);
        if (mem_req === 1'b1) wait_cnt++;
      end
    end
    prev_req = mem_req;
    prev_ack = mem_ack;
    prev_addr = mem_addr;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic fill_nop(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) mem[base + 16'(i)] = 8'hEA;
  endtask

  task automatic check_reset_outputs();
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, RESET_PC);
    check("rst_q_count", q_count, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_opcode", instr_opcode, 0);
    check("rst_operand", instr_operand, 0);
    check("rst_len", instr_len, 0);
    check("rst_pc", instr_pc, 0);
  endtask

  task automatic wait_valid(input int budget, output bit found);
    found = 0;
    for (int i = 0; i <= budget && !found; i++) begin
      if (instr_valid === 1'b1) found = 1;
      else step();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit found, seen_zero;
    logic [15:0] old_addr;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

    // reset values and first-instruction latency
    reset_n = 0; instr_ready = 1;
    step();
    fill_nop(16'h8000, 16);
    step();
    check_reset_outputs();
    reset_n = 1;
    step();
    check("t1_req", mem_req, 1);
    check("t1_addr", mem_addr, 16'h8000);
    step();
    check("t1_qcount", q_count, 1);
    check("t1_valid_c1", instr_valid, 0);
    step();
    check("t1_valid_c2", instr_valid, 1);
    check("t1_opcode", instr_opcode, 8'hEA);
    check("t1_len", instr_len, 1);
    check("t1_pc", instr_pc, 16'h8000);
    check("t1_operand", instr_operand, 0);

    // three-byte instruction
    reset_n = 0;
    step();
    mem[16'h8000] = 8'hAD; mem[16'h8001] = 8'h34; mem[16'h8002] = 8'h12;
    fill_nop(16'h8003, 8);
    step();
    reset_n = 1;
    wait_valid(20, found);
    check("t2_found", found, 1);
    check("t2_opcode", instr_opcode, 8'hAD);
    check("t2_operand", instr_operand, 16'h1234);
    check("t2_len", instr_len, 3);
    check("t2_pc", instr_pc, 16'h8000);
    step();
    wait_valid(20, found);
    check("t2_found2", found, 1);
    check("t2_pc2", instr_pc, 16'h8003);
    check("t2_opcode2", instr_opcode, 8'hEA);

    // back-pressure fills the queue and stops fetching
    reset_n = 0; instr_ready = 0;
    step();
    fill_nop(16'h8000, 64);
    step();
    reset_n = 1;
    repeat (20) step();
    check("t3_qcount", q_count, 4);
    check("t3_req", mem_req, 0);
    check("t3_valid", instr_valid, 1);
    check("t3_pc", instr_pc, 16'h8000);
    instr_ready = 1;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (mem_req) found = 1;
    end
    check("t3_resume", found, 1);
    check("t3_resume_addr", mem_addr, 16'h8005);

    // redirect while a slow request is outstanding
    reset_n = 0; fixed_lat = 3;
    step();
    fill_nop(16'h8000, 64);
    mem[16'hC000] = 8'hA9; mem[16'hC001] = 8'h55;
    fill_nop(16'hC002, 16);
    step();
    reset_n = 1;
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      step();
      if (mem_req && !mem_ack && instr_valid) found = 1;
    end
    check("t4_window", found, 1);
    old_addr = mem_addr;
    redirect = 1; redirect_pc = 16'hC000;
    step();
    redirect = 0;
    check("t4_valid_cleared", instr_valid, 0);
    check("t4_flushed", q_count, 0);
    check("t4_req_kept", mem_req, 1);
    check("t4_addr_kept", mem_addr, old_addr);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (mem_req && mem_addr == 16'hC000) found = 1;
    end
    check("t4_new_addr", found, 1);
    wait_valid(30, found);
    check("t4_found", found, 1);
    check("t4_pc", instr_pc, 16'hC000);
    check("t4_opcode", instr_opcode, 8'hA9);
    check("t4_operand", instr_operand, 16'h0055);
    check("t4_len", instr_len, 2);

    // fetch across the top of the address space
    fixed_lat = 0;
    mem[16'hFFFE] = 8'h4C; mem[16'hFFFF] = 8'h00; mem[16'h0000] = 8'h80;
    fill_nop(16'h0001, 16);
    redirect = 1; redirect_pc = 16'hFFFE;
    step();
    redirect = 0;
    found = 0; seen_zero = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (mem_req && mem_addr == 16'h0000) seen_zero = 1;
      if (instr_valid) found = 1;
      else step();
    end
    check("t5_found", found, 1);
    check("t5_opcode", instr_opcode, 8'h4C);
    check("t5_operand", instr_operand, 16'h8000);
    check("t5_len", instr_len, 3);
    check("t5_pc", instr_pc, 16'hFFFE);
    check("t5_addr_wrap", seen_zero, 1);

    // reset mid-request with a valid instruction, then a late ack
    reset_n = 0; fixed_lat = 3; instr_ready = 0;
    step();
    fill_nop(16'h8000, 64);
    step();
    reset_n = 1;
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      step();
      if (instr_valid && mem_req && !mem_ack) found = 1;
    end
    check("t6_window", found, 1);
    reset_n = 0; late_ack_arm = 1;
    step();
    check_reset_outputs();
    reset_n = 1;
    step();
    check("t6_no_push", q_count, 0);
    check("t6_req", mem_req, 1);
    check("t6_addr", mem_addr, 16'h8000);

    // random traffic
    instr_ready = 1; fixed_lat = -1;
    for (int i = 0; i < 4000; i++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      redirect = ($urandom_range(0, 49) == 0);
      redirect_pc = 16'($urandom);
      step();
    end
    redirect = 0; instr_ready = 1;
    repeat (10) step();
    check("progress", n_accepted > 200, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
